// File: rtl/oser4_tx.sv
// oser4_tx: 4:1 DDR serializer, PCLK word FIFO feeding a 2x FCLK bit shifter.
// Define TX_TRAIN_EN to include the TRAIN_PAT alignment-burst FSM; otherwise the block always runs.
`timescale 1ns/1ps
module oser4_tx #(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         TRAIN_WORDS = 16,
  parameter logic [3:0] TRAIN_PAT   = 4'b0011,
  parameter logic [3:0] IDLE_PAT    = 4'b0000
) (
  input  logic                                PCLK,
  input  logic                                RESET,
  input  logic                                FCLK,
  input  logic                                s_valid,
  input  logic [3:0]                          s_data,
  output logic                                s_ready,
  input  logic                                train_req,
  output logic                                training,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level,
  output logic                                Q
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    hold_q, hold_d;
  logic          ptog_q, ptog_d;
  logic          push, pop, run;

`ifdef TX_TRAIN_EN
  typedef enum logic {ST_TRAIN, ST_RUN} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  assign run      = (state_q == ST_RUN);
  assign training = (state_q == ST_TRAIN);
`else
  logic unused_train;
  assign unused_train = train_req ^ (^TRAIN_PAT) ^ (TRAIN_WORDS == 0);
  assign run      = 1'b1;
  assign training = 1'b0;
`endif

  assign s_ready = !RESET && (level_q < LW'(FIFO_DEPTH));
  assign level   = level_q;

  always_comb begin
    push     = s_valid && s_ready;
    pop      = run && (level_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    hold_d   = pop ? mem_q[rd_ptr_q] : IDLE_PAT;
    ptog_d   = ~ptog_q;
`ifdef TX_TRAIN_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_TRAIN) begin
      hold_d = TRAIN_PAT;
      if (train_req)                            cnt_d   = '0;
      else if (cnt_q == 8'(TRAIN_WORDS - 1))    state_d = ST_RUN;
      else                                      cnt_d   = cnt_q + 8'd1;
    end else if (train_req) begin
      state_d = ST_TRAIN;
      cnt_d   = '0;
    end
`endif
    // ptog is deliberately left free-running so the FCLK side keeps reloading through reset
    if (RESET) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      hold_d   = IDLE_PAT;
`ifdef TX_TRAIN_EN
      state_d  = ST_TRAIN;
      cnt_d    = '0;
`endif
    end
  end

  always_ff @(posedge PCLK) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
    hold_q   <= hold_d;
    ptog_q   <= ptog_d;
`ifdef TX_TRAIN_EN
    state_q  <= state_d;
    cnt_q    <= cnt_d;
`endif
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // FCLK side: a ptog/ftog mismatch marks the mid-PCLK posedge where hold is stable to sample.
  logic [3:0] fbuf_q, fbuf_d;
  logic       ftog_q, ftog_d, ld_q, ld_d, qp_q, qp_d, qn_q, qn_d;

  always_comb begin
    ld_d   = (ptog_q != ftog_q);
    fbuf_d = ld_d ? hold_q    : fbuf_q;
    ftog_d = ld_d ? ptog_q    : ftog_q;
    qp_d   = ld_d ? hold_q[0] : fbuf_q[2];
    qn_d   = ld_q ? fbuf_q[1] : fbuf_q[3];
  end

  always_ff @(posedge FCLK) begin
    fbuf_q <= fbuf_d;
    ftog_q <= ftog_d;
    ld_q   <= ld_d;
    qp_q   <= qp_d;
  end

  always_ff @(negedge FCLK) qn_q <= qn_d;

  assign Q = FCLK ? qp_q : qn_q;
endmodule

// File: tb/tb_oser4_tx.sv
// Self-checking bench for oser4_tx: queue-based word model, per-bit Q checks, directed + random stimulus.
`timescale 1ns/1ps
module tb_oser4_tx;
  localparam int         DEPTH = 4;
  localparam int         TW    = 16;
  localparam logic [3:0] TPAT  = 4'b0011;
  localparam logic [3:0] IPAT  = 4'b0000;
`ifdef TX_TRAIN_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic       PCLK = 1'b1, FCLK = 1'b1, RESET = 1'b1, s_valid = 1'b0, train_req = 1'b0;
  logic [3:0] s_data = 4'h0;
  logic       s_ready, training, Q;
  logic [2:0] level;
  int         n_tests = 0, n_fail = 0;

  oser4_tx dut (
    .PCLK(PCLK), .RESET(RESET), .FCLK(FCLK), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .train_req(train_req), .training(training), .level(level), .Q(Q)
  );

  // rising edges of FCLK at 10,20,30..; PCLK rises at 20,40.. (coincident)
  always #5  FCLK = ~FCLK;
  always #10 PCLK = ~PCLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] mq[$];
  int         train_left = 0;
  logic [3:0] cur_h = 4'h0, prev_h = 4'h0;
  bit         cur_k = 1'b0, prev_k = 1'b0, m_known = 1'b0;
  int         edges = 0;

  always @(posedge PCLK) begin : model
    bit         mpush;
    logic [3:0] h;
    edges++;
    mpush = s_valid && !RESET && (mq.size() < DEPTH);
    if (RESET) begin
      mq.delete();
      h = IPAT;
      train_left = TEN ? TW : 0;
    end else begin
      if (train_left > 0) begin
        h = TPAT;
        train_left = train_req ? TW : train_left - 1;
      end else begin
        if (mq.size() > 0) h = mq.pop_front();
        else               h = IPAT;
        if (TEN && train_req) train_left = TW;
      end
      if (mpush) mq.push_back(s_data);
    end
    prev_h = cur_h; prev_k = cur_k;
    cur_h = h; cur_k = 1'b1; m_known = 1'b1;
  end

  always @(negedge PCLK) begin : word_chk
    if (m_known) begin
      chk("s_ready", s_ready, (!RESET && mq.size() < DEPTH) ? 1 : 0);
      chk("level", level, mq.size());
      chk("training", training, (train_left > 0) ? 1 : 0);
    end
  end

  // word loaded at edge k: bits 0,1 in the second half of PCLK k, bits 2,3 in the first half of k+1
  always @(posedge PCLK) begin : q_chk
    logic [3:0] p, c;
    bit pk, ck;
    #2.5;
    p = prev_h; c = cur_h;
    pk = prev_k && (edges >= 3);
    ck = cur_k && (edges >= 3);
    if (pk) chk("q_bit2", Q, p[2]);
    #5;
    if (pk) chk("q_bit3", Q, p[3]);
    #5;
    if (ck) chk("q_bit0", Q, c[0]);
    #5;
    if (ck) chk("q_bit1", Q, c[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic send(input logic [3:0] w);
    bit acc;
    s_valid = 1'b1;
    s_data  = w;
    for (int g = 0; g < 200; g++) begin
      @(negedge PCLK);
      acc = s_ready;
      @(posedge PCLK);
      #1;
      if (acc) break;
      if (g == 199) chk("send_timeout", 0, 1);
    end
    s_valid = 1'b0;
  endtask

  task automatic count_train(output int c);
    c = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge PCLK);
      if (training) c++;
      else break;
    end
  endtask

  task automatic wait_run();
    int g;
    g = 0;
    do begin
      @(negedge PCLK);
      g++;
    end while (training && g < 100);
    chk("wait_run", training, 0);
  endtask

  initial begin
    logic [15:0] bits;
    int cnt;
    bits = '0;
    RESET = 1'b1;
    cyc(3);
    RESET = 1'b0;

    count_train(cnt);
    chk("post_reset_training_len", cnt, TEN ? 16 : 0);
    cyc(2);

    // streaming A,5,3: first bit 1.5 PCLK after the accepting edge, LSB first, then idle
    fork
      begin send(4'hA); send(4'h5); send(4'h3); end
      begin #51.5; for (int i = 0; i < 16; i++) begin bits[i] = Q; #5; end end
    join
    chk("stream_bits", bits, 16'h035A);
    cyc(4);

`ifndef TX_TRAIN_EN
    fork
      send(4'hC);
      begin #51.5; for (int i = 0; i < 8; i++) begin bits[i] = Q; #5; end end
    join
    chk("no_train_c_bits", bits[7:0], 8'h0C);
    train_req = 1'b1;
    cyc(1);
    train_req = 1'b0;
    count_train(cnt);
    chk("train_req_ignored", cnt, 0);
    cyc(4);
`else
    // backpressure during training
    RESET = 1'b1; cyc(1); RESET = 1'b0;
    fork
      begin for (int i = 0; i < 6; i++) send(4'(i + 7)); end
      begin
        repeat (8) @(negedge PCLK);
        chk("bp_level_full", level, 4);
        chk("bp_ready_low", s_ready, 0);
      end
    join
    cyc(10);

    // mid-stream retrain with level 3
    RESET = 1'b1; cyc(1); RESET = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 1));
    wait_run();
    cyc(1);
    train_req = 1'b1;
    @(negedge PCLK);
    chk("rt_level3", level, 3);
    @(posedge PCLK); #1;
    train_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      if (level == 3'd2 && training) cnt++;
    end
    chk("rt_frozen_cycles", cnt, 16);
    cyc(8);

    // reset mid-operation with level 3
    RESET = 1'b1; cyc(1); RESET = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 9));
    wait_run();
    cyc(1);
    RESET = 1'b1;
    @(negedge PCLK);
    chk("rst_ready_low", s_ready, 0);
    @(posedge PCLK); #1;
    RESET = 1'b0;
    chk("rst_level0", level, 0);
    count_train(cnt);
    chk("rst_training_len", cnt, 16);
    cyc(4);
`endif

    for (int i = 0; i < 1500; i++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = 4'($urandom);
      train_req = ($urandom_range(0, 39) == 0);
      RESET     = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    s_valid = 1'b0; train_req = 1'b0; RESET = 1'b0;
    cyc(40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/oser4_tx.md
# oser4_tx

4:1 DDR serializer: the transmit-side counterpart of the IDES4 4:1 deserializer model used on the bench. It accepts 4-bit words in the PCLK domain through a valid/ready handshake and buffers them in a small FIFO. It emits each word bit-serially on both edges of FCLK, at 2x PCLK. After reset, or on request, a training FSM sends a fixed alignment pattern so the receiver can step its word-alignment pointer.

## Interface

Parameters:
- FIFO_DEPTH, 4: FIFO capacity in words; power of 2, at least 2.
- TRAIN_WORDS, 16: length of a training burst in PCLK cycles; 1..255.
- TRAIN_PAT, 4'b0011: word sent during training.
- IDLE_PAT, 4'b0000: word sent when no data is available.

Ports:
- PCLK  in  1  word clock.
- RESET  in  1  reset, synchronous to PCLK, active-high.
- FCLK  in  1  bit clock: 2x PCLK, rising edges coincident with PCLK rising edges.
- s_valid  in  1  word offered.
- s_data  in  4  word; bit 0 is transmitted first.
- s_ready  out  1  FIFO can accept a word.
- train_req  in  1  single-cycle request to start a training burst.
- training  out  1  training burst in progress.
- level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- Q  out  1  serial DDR output.

## Operation

- **Push:** on a PCLK edge with s_valid && s_ready. s_ready = !RESET && level < FIFO_DEPTH. There is no push-at-full bypass.
- **FSM, TRAIN state:**
  - hold <= TRAIN_PAT every cycle.
  - A counter runs 0..TRAIN_WORDS-1; on the final count the FSM goes to RUN.
  - FIFO contents are kept and nothing is popped.
  - train_req restarts the counter at 0.
- **FSM, RUN state:**
  - If level > 0: pop the head into hold.
  - Otherwise: hold <= IDLE_PAT.
  - train_req moves the FSM to TRAIN on the next edge and the counter resets to 0. The word loaded on that same edge still follows RUN rules.
- **Push and pop in the same cycle:** level is unchanged.
- **ptog:** a PCLK-domain flag that toggles every PCLK cycle, including during reset.
- **FCLK posedge:**
  - If ptog != ftog, where ftog is the FCLK-domain copy: fbuf <= hold, ftog <= ptog, Q <= hold[0].
  - Else: Q <= fbuf[2].
- **FCLK negedge:** Q <= fbuf[1] on the half-cycle after a load, otherwise fbuf[3].
- **Serial order per word:** bit0, bit1, bit2, bit3. This matches a receiver that presents the first bit on Q0.
- **Reset (any time, including mid-burst or mid-training):**
  - FIFO flushed; level = 0; s_ready = 0.
  - hold = IDLE_PAT.
  - FSM = TRAIN, counter = 0, training = 1. Without the macro: FSM = RUN, training = 0.
  - FCLK-domain registers (fbuf, ftog, Q) have no reset. They reflect IDLE_PAT within 2 PCLK cycles of RESET assertion because ptog keeps toggling.

## Timing

- **Push to pop:** a word pushed at edge n is earliest popped into hold at edge n+1. This requires RUN state and that it is the FIFO head.
- **hold to Q:** hold written at PCLK edge k is loaded into fbuf at the FCLK posedge half a PCLK after k.
  - bit0 is driven from that edge, bit1 from the following negedge.
  - bit2 is driven from PCLK edge k+1, bit3 from the following negedge.
- **End-to-end latency:** first bit appears 1.5 PCLK cycles after push, with an empty FIFO in RUN.
- **Training flag:** training asserts on the edge the FSM enters TRAIN and deasserts on the edge it enters RUN. Exactly TRAIN_WORDS hold loads use TRAIN_PAT.
- **Throughput:** 1 word per PCLK; Q is continuous with no gaps between words.

## Configuration

- **TX_TRAIN_EN defined:** training FSM as described above; TRAIN_PAT bursts after reset and on train_req.
- **TX_TRAIN_EN undefined:**
  - FSM and counter removed; the block is permanently in RUN.
  - train_req ignored; training tied 0.
  - Data flows from the first cycle after reset.

## Test plan

- **Post-reset training:** release RESET, keep s_valid = 0 (TX_TRAIN_EN defined) -> training = 1 for exactly 16 cycles. Q repeats 1,1,0,0 per word for 16 words, then all 0 (IDLE_PAT).
- **Streaming:** after training, push 4'hA, 4'h5, 4'h3 on consecutive cycles -> Q = 0,1,0,1, 1,0,1,0, 1,1,0,0 contiguously, starting 1.5 PCLK after the first push, then 0s.
- **Backpressure:**
  - Hold s_valid with 6 words during training -> 4 accepted, s_ready = 0, level = 4.
  - After training -> one pop per cycle, and the remaining 2 words are accepted as space frees.
  - Order preserved on Q.
- **Mid-stream retrain:** level = 3, pulse train_req -> one more data word, then 16 TRAIN_PAT words with level frozen at 2, then the remaining 2 words in order.
- **Reset mid-operation:** level = 3 in RUN, assert RESET 1 cycle -> level = 0, s_ready = 0 during reset, Q = 0s within 2 cycles, training restarts with a full 16 words.
- **TX_TRAIN_EN undefined:** release RESET, push 4'hC -> no training; Q = 0,0,1,1 starting 1.5 PCLK after push; train_req has no effect.
